enet_mii_rx_framer: RTL and testbench

Receive framer directly downstream of the RMII-to-MII RX converter, in the `rmii_ref_clk` domain. It consumes the MII nibble stream, using `mii_rx_clk` as a data strobe rather than a clock. It strips preamble/SFD and packs nibbles (low nibble first) into bytes. It outputs a byte stream with start/end markers and per-frame error status for the MAC RX buffer.

---
 rtl/enet_mii_rx_framer.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_enet_mii_rx_framer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enet_mii_rx_framer.sv
// -----------------------------------------------------------------------------
// enet_mii_rx_framer
//
// Receive framer that sits directly behind the RMII-to-MII RX converter and
// runs entirely in the rmii_ref_clk domain. The MII nibble clock is sampled as
// an ordinary data level: its rising edge, detected against a registered copy,
// forms a one-cycle nibble strobe. All framing state moves only on that strobe.
//
// The framer strips preamble and SFD, packs nibbles (low nibble first) into
// bytes and emits them through a one-byte hold register. Holding one byte back
// lets the final byte carry rx_eof and the frame status when dv falls.
//
// Optional feature macro:
//   ENET_RX_CRC_CHECK_EN - builds the CRC-32 residue checker that drives
//                          rx_err[3]. When undefined no CRC logic exists and
//                          rx_err[3] is always 0.
//
// Parameters:
//   PRE_MIN      minimum number of 0x5 nibbles before the SFD nibble
//   MIN_LEN      minimum legal frame length in bytes (FCS included)
//   MAX_LEN      maximum legal frame length in bytes (FCS included)
//
// Ports:
//   rmii_ref_clk in   sole clock
//   rst_ref_n    in   asynchronous active-low reset
//   mii_rx_clk   in   MII RX clock level, treated as data
//   mii_rx_dv    in   MII data valid
//   mii_rx_er    in   MII receive error
//   mii_rxd      in   MII nibble
//   rx_data      out  frame byte
//   rx_valid     out  one-cycle byte strobe, no backpressure
//   rx_sof       out  marks the first byte of a frame
//   rx_eof       out  marks the last byte of a frame
//   rx_err       out  {crc, phy, len, align}, meaningful only with rx_eof
//   rx_abort     out  one-cycle pulse: frame ended after SFD with zero bytes
// -----------------------------------------------------------------------------
module enet_mii_rx_framer #(
   parameter int unsigned PRE_MIN = 4,
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518
) (
   input  logic       rmii_ref_clk,
   input  logic       rst_ref_n,
   input  logic       mii_rx_clk,
   input  logic       mii_rx_dv,
   input  logic       mii_rx_er,
   input  logic [3:0] mii_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_sof,
   output logic       rx_eof,
   output logic [3:0] rx_err,
   output logic       rx_abort
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2,
      ST_DROP = 2'd3
   } state_e;

   localparam logic [3:0]  NIB_PRE     = 4'h5;
   localparam logic [3:0]  NIB_SFD     = 4'hD;
   localparam logic [3:0]  PRE_CNT_MAX = 4'hF;
   localparam logic [10:0] CNT_MAX     = 11'd2047;

`ifdef ENET_RX_CRC_CHECK_EN
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   // One byte of reflected CRC-32, processed LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                              input logic [7:0]  data_in);
      logic [31:0] c;
      c = crc_in ^ {24'd0, data_in};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction
`endif

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_e      state_q,    state_d;
   logic        rxclk_q,    rxclk_d;     // previous mii_rx_clk level
   logic [3:0]  pre_cnt_q,  pre_cnt_d;   // preamble nibbles seen
   logic        half_q,     half_d;      // low nibble of current byte latched
   logic [3:0]  low_q,      low_d;
   logic [10:0] cnt_q,      cnt_d;       // completed bytes in this frame
   logic [7:0]  hold_q,     hold_d;      // byte waiting to be emitted
   logic        phy_q,      phy_d;       // sticky mii_rx_er seen in DATA
`ifdef ENET_RX_CRC_CHECK_EN
   logic [31:0] crc_q,      crc_d;
`endif

   logic [7:0]  rx_data_q,  rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_sof_q,   rx_sof_d;
   logic        rx_eof_q,   rx_eof_d;
   logic [3:0]  rx_err_q,   rx_err_d;
   logic        rx_abort_q, rx_abort_d;

   // ---------------------------------------------------------------------------
   // Derived combinational terms
   // ---------------------------------------------------------------------------
   logic       stb;
   logic       pre_ok;
   logic       len_bad;
   logic       crc_bad;
   logic       held;
   logic [7:0] byte_w;

   // Rising edge of the MII clock level, one rmii_ref_clk cycle wide.
   assign stb     = mii_rx_clk & ~rxclk_q;
   assign pre_ok  = 32'(pre_cnt_q) >= PRE_MIN;
   assign len_bad = (32'(cnt_q) < MIN_LEN) || (32'(cnt_q) > MAX_LEN);
   assign byte_w  = {mii_rxd, low_q};

   // cnt counts completed bytes and saturates high, so a non-zero count means
   // the hold register carries a byte, and a count of one means that byte is
   // the first of the frame.
   assign held    = (cnt_q != 11'd0);

`ifdef ENET_RX_CRC_CHECK_EN
   assign crc_bad = (crc_q != CRC_RESIDUE);
`else
   assign crc_bad = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Process 1: state register
   // ---------------------------------------------------------------------------
   // NOTE: every flop uses non-blocking assignment so all registers sample the
   // same pre-edge values regardless of process ordering.
   always_ff @(posedge rmii_ref_clk or negedge rst_ref_n) begin
      if (!rst_ref_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Process 2: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (stb) begin
         case (state_q)
            ST_IDLE: begin
               if (mii_rx_dv) begin
                  state_d = (mii_rxd == NIB_PRE) ? ST_PRE : ST_DROP;
               end
            end
            ST_PRE: begin
               if (!mii_rx_dv) begin
                  state_d = ST_IDLE;
               end else if (mii_rxd == NIB_SFD) begin
                  state_d = pre_ok ? ST_DATA : ST_DROP;
               end else if (mii_rxd != NIB_PRE) begin
                  state_d = ST_DROP;
               end
            end
            ST_DATA, ST_DROP: begin
               if (!mii_rx_dv) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Process 3: datapath and registered outputs
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here receives a default first, so no path can
   // leave it unassigned and infer a latch; the pulse outputs default to 0,
   // which is what makes them one cycle wide.
   always_comb begin
      rxclk_d    = mii_rx_clk;
      pre_cnt_d  = pre_cnt_q;
      half_d     = half_q;
      low_d      = low_q;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      phy_d      = phy_q;
`ifdef ENET_RX_CRC_CHECK_EN
      crc_d      = crc_q;
`endif
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_sof_d   = 1'b0;
      rx_eof_d   = 1'b0;
      rx_err_d   = 4'd0;
      rx_abort_d = 1'b0;

      if (stb) begin
         case (state_q)
            ST_IDLE: begin
               // First preamble nibble counts as one.
               pre_cnt_d = 4'd1;
            end

            ST_PRE: begin
               if (mii_rx_dv) begin
                  if (mii_rxd == NIB_PRE && pre_cnt_q != PRE_CNT_MAX) begin
                     pre_cnt_d = pre_cnt_q + 4'd1;
                  end
                  // Accepted SFD: start a fresh frame context.
                  if (mii_rxd == NIB_SFD && pre_ok) begin
                     half_d = 1'b0;
                     cnt_d  = 11'd0;
                     phy_d  = 1'b0;
`ifdef ENET_RX_CRC_CHECK_EN
                     crc_d  = CRC_INIT;
`endif
                  end
               end
            end

            ST_DATA: begin
               if (mii_rx_dv) begin
                  if (mii_rx_er) begin
                     phy_d = 1'b1;
                  end
                  if (!half_q) begin
                     low_d  = mii_rxd;
                     half_d = 1'b1;
                  end else begin
                     // Byte completes: it replaces the held byte, which goes out.
                     half_d = 1'b0;
                     hold_d = byte_w;
                     if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 11'd1;
                     end
`ifdef ENET_RX_CRC_CHECK_EN
                     crc_d = crc32_byte(crc_q, byte_w);
`endif
                     if (held) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = hold_q;
                        rx_sof_d   = (cnt_q == 11'd1);
                     end
                  end
               end else begin
                  // dv fell: flush the held byte with status, or flag an empty
                  // frame. A dangling low nibble is dropped and shows as align.
                  if (held) begin
                     rx_valid_d = 1'b1;
                     rx_data_d  = hold_q;
                     rx_sof_d   = (cnt_q == 11'd1);
                     rx_eof_d   = 1'b1;
                     rx_err_d   = {crc_bad, phy_q, len_bad, half_q};
                  end else begin
                     rx_abort_d = 1'b1;
                  end
               end
            end

            default: begin
               // DROP: swallow nibbles until dv falls.
            end
         endcase
      end
   end

   // NOTE: the hold register and counters are reset as well, because a reset
   // in the middle of a frame must not let a stale byte leak into the next one.
   always_ff @(posedge rmii_ref_clk or negedge rst_ref_n) begin
      if (!rst_ref_n) begin
         rxclk_q    <= 1'b0;
         pre_cnt_q  <= 4'd0;
         half_q     <= 1'b0;
         low_q      <= 4'd0;
         cnt_q      <= 11'd0;
         hold_q     <= 8'd0;
         phy_q      <= 1'b0;
`ifdef ENET_RX_CRC_CHECK_EN
         crc_q      <= 32'hFFFF_FFFF;
`endif
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         rx_sof_q   <= 1'b0;
         rx_eof_q   <= 1'b0;
         rx_err_q   <= 4'd0;
         rx_abort_q <= 1'b0;
      end else begin
         rxclk_q    <= rxclk_d;
         pre_cnt_q  <= pre_cnt_d;
         half_q     <= half_d;
         low_q      <= low_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         phy_q      <= phy_d;
`ifdef ENET_RX_CRC_CHECK_EN
         crc_q      <= crc_d;
`endif
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_sof_q   <= rx_sof_d;
         rx_eof_q   <= rx_eof_d;
         rx_err_q   <= rx_err_d;
         rx_abort_q <= rx_abort_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_sof   = rx_sof_q;
   assign rx_eof   = rx_eof_q;
   assign rx_err   = rx_err_q;
   assign rx_abort = rx_abort_q;

endmodule

// File: tb/tb_enet_mii_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_enet_mii_rx_framer
//
// Self-checking bench for enet_mii_rx_framer. Frames are described as a plain
// list of MII nibbles; a reference model parses that list with the framing
// rules (preamble count, SFD, byte packing, length, residue CRC) and predicts
// the byte stream and status. A table of directed frames carries hand-written
// expectations, followed by a mid-frame reset sequence and randomized frames.
// -----------------------------------------------------------------------------
module tb_enet_mii_rx_framer;

   localparam int PRE_MIN = 4;
   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;
   localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

`ifdef ENET_RX_CRC_CHECK_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       mii_rx_clk;
   logic       mii_rx_dv;
   logic       mii_rx_er;
   logic [3:0] mii_rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_sof;
   logic       rx_eof;
   logic [3:0] rx_err;
   logic       rx_abort;

   enet_mii_rx_framer #(
      .PRE_MIN (PRE_MIN),
      .MIN_LEN (MIN_LEN),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .rmii_ref_clk (clk),
      .rst_ref_n    (rst_n),
      .mii_rx_clk   (mii_rx_clk),
      .mii_rx_dv    (mii_rx_dv),
      .mii_rx_er    (mii_rx_er),
      .mii_rxd      (mii_rxd),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_sof       (rx_sof),
      .rx_eof       (rx_eof),
      .rx_err       (rx_err),
      .rx_abort     (rx_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Frame under test, one entry per MII nibble with its rx_er level.
   logic [3:0] tx_nib[$];
   logic       tx_er[$];
   int         last_cyc;
   int         fall_cyc;

   // Observed output events, captured away from the active edge.
   logic [7:0] obs_data[$];
   logic       obs_sof[$];
   logic       obs_eof[$];
   logic [3:0] obs_err[$];
   int         obs_cyc[$];
   int         obs_abort[$];
   int         obs_stray[$];

   always @(negedge clk) begin
      if (rx_valid) begin
         obs_data.push_back(rx_data);
         obs_sof.push_back(rx_sof);
         obs_eof.push_back(rx_eof);
         obs_err.push_back(rx_err);
         obs_cyc.push_back(cyc);
      end
      if (rx_abort) obs_abort.push_back(cyc);
      if ((rx_sof || rx_eof) && !rx_valid) obs_stray.push_back(cyc);
   end

   // Model results.
   logic [7:0] model_bytes[$];
   logic [3:0] model_err;
   bit         model_abort;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in ^ {24'd0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   // Build a frame: n_pre 0x5 nibbles, one sfd nibble, n_bytes bytes (the last
   // four being the FCS when n_bytes >= 4), an optional dangling nibble, and
   // rx_er raised on data nibble er_at (-1 for none).
   task automatic build(input int n_pre, input logic [3:0] sfd, input int n_bytes,
                        input bit good_fcs, input bit odd, input int er_at, input bit rnd);
      logic [7:0]  pay[$];
      logic [31:0] c;
      int          p;
      int          dn;
      tx_nib.delete();
      tx_er.delete();
      for (int k = 0; k < n_pre; k++) begin
         tx_nib.push_back(4'h5);
         tx_er.push_back(1'b0);
      end
      tx_nib.push_back(sfd);
      tx_er.push_back(1'b0);
      p = (n_bytes >= 4) ? n_bytes - 4 : n_bytes;
      for (int k = 0; k < p; k++) pay.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(k));
      if (n_bytes >= 4) begin
         c = 32'hFFFF_FFFF;
         foreach (pay[k]) c = crc_step(c, pay[k]);
         c = ~c;
         if (!good_fcs) c[7:0] = c[7:0] ^ 8'h5A;
         for (int k = 0; k < 4; k++) pay.push_back(c[8*k +: 8]);
      end
      dn = 0;
      foreach (pay[k]) begin
         tx_nib.push_back(pay[k][3:0]);
         tx_er.push_back(dn == er_at);
         dn++;
         tx_nib.push_back(pay[k][7:4]);
         tx_er.push_back(dn == er_at);
         dn++;
      end
      if (odd) begin
         tx_nib.push_back(4'hA);
         tx_er.push_back(dn == er_at);
      end
   endtask

   // Reference model: parse the nibble list with the framing rules.
   task automatic run_model();
      int          i;
      int          n5;
      logic [31:0] c;
      logic [3:0]  d[$];
      bit          phy;
      bit          len_bad;
      i = 0;
      n5 = 0;
      phy = 1'b0;
      c = 32'hFFFF_FFFF;
      model_bytes.delete();
      model_err = 4'd0;
      model_abort = 1'b0;
      while (i < tx_nib.size() && tx_nib[i] == 4'h5) begin
         n5++;
         i++;
      end
      if (n5 == 0 || i >= tx_nib.size() || tx_nib[i] != 4'hD || n5 < PRE_MIN) return;
      for (int k = i + 1; k < tx_nib.size(); k++) begin
         d.push_back(tx_nib[k]);
         if (tx_er[k]) phy = 1'b1;
      end
      for (int k = 0; k + 1 < d.size(); k += 2) model_bytes.push_back({d[k+1], d[k]});
      if (model_bytes.size() == 0) begin
         model_abort = 1'b1;
         return;
      end
      foreach (model_bytes[k]) c = crc_step(c, model_bytes[k]);
      len_bad = (model_bytes.size() < MIN_LEN) || (model_bytes.size() > MAX_LEN);
      model_err = {CRC_ON && (c != RESIDUE), phy, len_bad, (d.size() % 2) == 1};
   endtask

   // One MII nibble period: low phase then high phase, half cycles each.
   task automatic strobe(input logic dv, input logic er, input logic [3:0] d, input int half);
      @(negedge clk);
      mii_rx_clk = 1'b0;
      repeat (half) @(negedge clk);
      mii_rx_clk = 1'b1;
      mii_rx_dv  = dv;
      mii_rx_er  = er;
      mii_rxd    = d;
      last_cyc   = cyc;
      repeat (half - 1) @(negedge clk);
   endtask

   task automatic send(input int half);
      for (int k = 0; k < tx_nib.size(); k++) strobe(1'b1, tx_er[k], tx_nib[k], half);
      strobe(1'b0, 1'b0, 4'h0, half);
      fall_cyc = last_cyc;
      repeat (3) strobe(1'b0, 1'b0, 4'h0, half);
      repeat (4) @(posedge clk);
   endtask

   task automatic clear_obs();
      obs_data.delete();
      obs_sof.delete();
      obs_eof.delete();
      obs_err.delete();
      obs_cyc.delete();
      obs_abort.delete();
      obs_stray.delete();
   endtask

   task automatic check_frame(input string tag, input int half, input int exp_n,
                              input logic [3:0] exp_err, input bit exp_abort);
      int n;
      int bad_data;
      int bad_sof;
      int bad_eof;
      int bad_gap;
      n = obs_data.size();
      check({tag, "_count"}, n, exp_n);
      check({tag, "_abort"}, obs_abort.size(), exp_abort);
      check({tag, "_stray"}, obs_stray.size(), 0);
      if (n == exp_n && n > 0) begin
         bad_data = 0;
         bad_sof  = 0;
         bad_eof  = 0;
         bad_gap  = 0;
         for (int k = 0; k < n; k++) begin
            if (k >= model_bytes.size() || obs_data[k] !== model_bytes[k]) bad_data++;
            if (obs_sof[k] !== (k == 0)) bad_sof++;
            if (obs_eof[k] !== (k == n - 1)) bad_eof++;
            if (k >= 1 && k <= n - 2 && (obs_cyc[k] - obs_cyc[k-1]) != 4 * half) bad_gap++;
         end
         check({tag, "_data_mismatches"}, bad_data, 0);
         check({tag, "_sof_mismatches"}, bad_sof, 0);
         check({tag, "_eof_mismatches"}, bad_eof, 0);
         check({tag, "_spacing_mismatches"}, bad_gap, 0);
         check({tag, "_err"}, obs_err[n-1], exp_err);
         check({tag, "_eof_latency"}, obs_cyc[n-1], fall_cyc + 1);
      end
      if (exp_abort && obs_abort.size() == 1) begin
         check({tag, "_abort_latency"}, obs_abort[0], fall_cyc + 1);
      end
   endtask

   typedef struct {
      int         half;
      int         n_pre;
      logic [3:0] sfd;
      int         n_bytes;
      bit         good_fcs;
      bit         odd;
      int         er_at;
      int         exp_n;
      logic [3:0] exp_err;
      bit         exp_abort;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs[NVEC];

   initial begin
      //          half pre sfd    bytes fcs odd er   exp_n exp_err              abort
      vecs[0]  = '{1,  7,  4'hD,  64,   1,  0,  -1,  64,   4'b0000,             0};
      vecs[1]  = '{10, 7,  4'hD,  64,   1,  0,  -1,  64,   4'b0000,             0};
      vecs[2]  = '{1,  7,  4'hD,  20,   1,  0,  -1,  20,   4'b0010,             0};
      vecs[3]  = '{1,  7,  4'hD,  64,   0,  0,  -1,  64,   {CRC_ON, 3'b000},    0};
      vecs[4]  = '{1,  7,  4'hD,  64,   1,  1,  21,  64,   4'b0101,             0};
      vecs[5]  = '{1,  2,  4'hD,  10,   1,  0,  -1,  0,    4'b0000,             0};
      vecs[6]  = '{1,  0,  4'h3,  10,   1,  0,  -1,  0,    4'b0000,             0};
      vecs[7]  = '{1,  7,  4'hD,  0,    1,  0,  -1,  0,    4'b0000,             1};
      vecs[8]  = '{1,  4,  4'hD,  64,   1,  0,  -1,  64,   4'b0000,             0};
      vecs[9]  = '{1,  3,  4'hD,  64,   1,  0,  -1,  0,    4'b0000,             0};
      vecs[10] = '{1,  7,  4'hD,  63,   1,  0,  -1,  63,   4'b0010,             0};
      vecs[11] = '{1,  7,  4'hD,  1,    1,  0,  -1,  1,    {CRC_ON, 3'b010},    0};
      vecs[12] = '{1,  7,  4'hD,  1518, 1,  0,  -1,  1518, 4'b0000,             0};
      vecs[13] = '{1,  7,  4'hD,  1519, 1,  0,  -1,  1519, 4'b0010,             0};
      vecs[14] = '{1,  7,  4'hD,  0,    1,  1,  -1,  0,    4'b0000,             1};
      vecs[15] = '{3,  7,  4'hD,  64,   1,  0,  0,   64,   4'b0100,             0};

      rst_n      = 1'b0;
      mii_rx_clk = 1'b0;
      mii_rx_dv  = 1'b0;
      mii_rx_er  = 1'b0;
      mii_rxd    = 4'h0;
      repeat (5) @(negedge clk);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_rx_sof", rx_sof, 1'b0);
      check("rst_rx_eof", rx_eof, 1'b0);
      check("rst_rx_err", rx_err, 4'h0);
      check("rst_rx_abort", rx_abort, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Directed table.
      for (int v = 0; v < NVEC; v++) begin
         build(vecs[v].n_pre, vecs[v].sfd, vecs[v].n_bytes, vecs[v].good_fcs,
               vecs[v].odd, vecs[v].er_at, 1'b0);
         run_model();
         clear_obs();
         send(vecs[v].half);
         check_frame($sformatf("vec%0d", v), vecs[v].half, vecs[v].exp_n,
                     vecs[v].exp_err, vecs[v].exp_abort);
      end

      // Reset in the middle of DATA, then a clean frame.
      build(7, 4'hD, 64, 1'b1, 1'b0, -1, 1'b1);
      clear_obs();
      for (int k = 0; k < 60; k++) strobe(1'b1, tx_er[k], tx_nib[k], 1);
      check("mid_frame_bytes_seen", obs_data.size() > 0, 1'b1);
      #2 rst_n = 1'b0;
      #1 check("mid_rst_outputs", {rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_abort}, 0);
      mii_rx_dv = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      build(7, 4'hD, 64, 1'b1, 1'b0, -1, 1'b0);
      run_model();
      clear_obs();
      send(1);
      check_frame("post_rst", 1, 64, 4'b0000, 1'b0);

      // Randomized frames against the reference model.
      for (int f = 0; f < 40; f++) begin
         int half;
         half = ($urandom_range(0, 3) == 0) ? 3 : 1;
         if (f % 4 == 0) begin
            build(7, 4'hD, $urandom_range(64, 72), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 100)), 1'b1);
         end else begin
            int n_pre;
            int n_dat;
            tx_nib.delete();
            tx_er.delete();
            n_pre = $urandom_range(0, 8);
            for (int k = 0; k < n_pre; k++) begin
               tx_nib.push_back(4'h5);
               tx_er.push_back(1'($urandom_range(0, 19) == 0));
            end
            tx_nib.push_back(($urandom_range(0, 3) != 0) ? 4'hD : 4'($urandom_range(0, 15)));
            tx_er.push_back(1'b0);
            n_dat = $urandom_range(0, 24);
            for (int k = 0; k < n_dat; k++) begin
               tx_nib.push_back(4'($urandom_range(0, 15)));
               tx_er.push_back(1'($urandom_range(0, 19) == 0));
            end
         end
         run_model();
         clear_obs();
         send(half);
         check_frame($sformatf("rand%0d", f), half, model_bytes.size(), model_err, model_abort);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
